dual_hbridge_pwm_driver: RTL and testbench

- Consumer end of the drive-train command interface: takes the per-wheel direction bits (FWD_x/BWD_x) and 2-bit duty selects produced by the direction-control state machines, and generates L298N-style H-bridge signals (PWM enable plus IN1/IN2) for motors A and B.
- Enforces period-aligned command updates, a dead interval on every direction reversal, and safe handling of illegal commands.

---
 rtl/dual_hbridge_pwm_driver_pkg.sv | 31 +++
 rtl/dual_hbridge_pwm_driver_hbridge_channel.sv | 137 +++++++++++++
 rtl/dual_hbridge_pwm_driver.sv | 88 ++++++++
 tb/tb_dual_hbridge_pwm_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_hbridge_pwm_driver_pkg.sv
// Shared encodings and default timing for the dual H-bridge PWM driver:
// duty-select codes, the per-channel state encoding and the duty threshold
// helper used by each channel's PWM compare.
package dual_hbridge_pwm_driver_pkg;

  // 25 kHz PWM from a 100 MHz clock, four whole periods of coast on reversal
  localparam int DEF_PWM_PERIOD   = 4000;
  localparam int DEF_DEAD_PERIODS = 4;

  typedef enum logic [1:0] {
    DUTY_25  = 2'b00,
    DUTY_50  = 2'b01,
    DUTY_75  = 2'b10,
    DUTY_100 = 2'b11
  } duty_t;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    FWD  = 2'b01,
    BWD  = 2'b10,
    DEAD = 2'b11
  } chan_state_t;

  // High-time threshold in clocks: PWM_PERIOD * (code + 1) / 4. The top code
  // equals the full period, so the compare never goes low and the output
  // stays solid across the wrap.
  function automatic int duty_threshold(input int period, input duty_t code);
    return (period * (int'(code) + 1)) / 4;
  endfunction

endpackage

// File: rtl/dual_hbridge_pwm_driver_hbridge_channel.sv
// hbridge_channel: one L298N-style motor channel. Direction/duty commands are
// sampled only on the period tick, so IN1/IN2 and the duty change only at a
// period boundary. A FWD<->BWD reversal passes through DEAD for DEAD_PERIODS
// whole periods with the bridge coasting. Outputs are registered and are
// computed for the cycle that follows each edge, so they line up exactly with
// the shared counter value of that cycle.
// Optional build macro: BRAKE_ON_STOP_EN (STOP drives IN1=IN2=PWM=1).
module hbridge_channel
  import dual_hbridge_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS,
  parameter int CNT_W        = $clog2(PWM_PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             period_tick,
  input  logic [CNT_W-1:0] cnt,
  input  logic             fwd,
  input  logic             bwd,
  input  logic [1:0]       duty_sel,
  output logic             pwm,
  output logic             in1,
  output logic             in2,
  output logic             illegal
);

  localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  chan_state_t       state, state_n;
  duty_t             duty_q, duty_n;
  logic [DEAD_W-1:0] dead_cnt, dead_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              req_fwd, req_bwd;
  logic              pwm_n, in1_n, in2_n;

  assign illegal = fwd & bwd;

  // Enable=0 and an illegal pair both reduce to "no request"
  assign req_fwd = enable & fwd & ~bwd;
  assign req_bwd = enable & bwd & ~fwd;

  // Next state, shadow duty and output decode for the cycle after this edge
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n = state;
    dead_n  = dead_cnt;
    duty_n  = duty_q;
    pwm_n   = 1'b0;
    in1_n   = 1'b0;
    in2_n   = 1'b0;
    cnt_n   = period_tick ? '0 : cnt + 1'b1;

    if (period_tick) begin
      duty_n = duty_t'(duty_sel);
      case (state)
        STOP: begin
          if (req_fwd)      state_n = FWD;
          else if (req_bwd) state_n = BWD;
        end
        FWD: begin
          if (req_bwd) begin
            state_n = DEAD;
            dead_n  = '0;
          end else if (!req_fwd) begin
            state_n = STOP;
          end
        end
        BWD: begin
          if (req_fwd) begin
            state_n = DEAD;
            dead_n  = '0;
          end else if (!req_bwd) begin
            state_n = STOP;
          end
        end
        DEAD: begin
          // The dead interval always runs its full length; the exit direction
          // is whatever is requested on the final tick.
          if (dead_cnt == DEAD_LAST) begin
            dead_n = '0;
            if (req_fwd)      state_n = FWD;
            else if (req_bwd) state_n = BWD;
            else              state_n = STOP;
          end else begin
            dead_n = dead_cnt + 1'b1;
          end
        end
        default: state_n = STOP;
      endcase
    end

    case (state_n)
      FWD: begin
        in1_n = 1'b1;
        pwm_n = int'(cnt_n) < duty_threshold(PWM_PERIOD, duty_n);
      end
      BWD: begin
        in2_n = 1'b1;
        pwm_n = int'(cnt_n) < duty_threshold(PWM_PERIOD, duty_n);
      end
`ifdef BRAKE_ON_STOP_EN
      STOP: begin
        in1_n = 1'b1;
        in2_n = 1'b1;
        pwm_n = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Channel state, dead counter, shadow duty and registered bridge outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      dead_cnt <= '0;
      duty_q   <= DUTY_25;
      pwm      <= 1'b0;
      in1      <= 1'b0;
      in2      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state    <= state_n;
      dead_cnt <= dead_n;
      duty_q   <= duty_n;
      pwm      <= pwm_n;
      in1      <= in1_n;
      in2      <= in2_n;
    end
  end

endmodule

// File: rtl/dual_hbridge_pwm_driver.sv
// dual_hbridge_pwm_driver: drives two L298N-style H-bridges (motors A and B)
// from per-wheel direction bits and 2-bit duty selects. Holds the shared PWM
// period counter, the period tick and the combined illegal-command Fault
// pulse; each motor is an independent hbridge_channel.
// Optional build macro: BRAKE_ON_STOP_EN (active brake in STOP).
module dual_hbridge_pwm_driver
  import dual_hbridge_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic       FWD_A,
  input  logic       BWD_A,
  input  logic       FWD_B,
  input  logic       BWD_B,
  input  logic [1:0] Duty_SelA,
  input  logic [1:0] Duty_SelB,
  output logic       PWM_A,
  output logic       PWM_B,
  output logic       IN1_A,
  output logic       IN2_A,
  output logic       IN1_B,
  output logic       IN2_B,
  output logic       Fault,
  output logic       Period_Tick
);

  localparam int CNT_W = $clog2(PWM_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             illegal_a, illegal_b;

  // Free-running period counter 0..PWM_PERIOD-1 shared by both channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign Period_Tick = (cnt == CNT_LAST);

  // Illegal commands only matter when they are sampled, i.e. on the tick;
  // both channels illegal together still give a single pulse.
  assign Fault = Period_Tick & (illegal_a | illegal_b);

  hbridge_channel #(
    .PWM_PERIOD   (PWM_PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (Enable),
    .period_tick (Period_Tick),
    .cnt         (cnt),
    .fwd         (FWD_A),
    .bwd         (BWD_A),
    .duty_sel    (Duty_SelA),
    .pwm         (PWM_A),
    .in1         (IN1_A),
    .in2         (IN2_A),
    .illegal     (illegal_a)
  );

  hbridge_channel #(
    .PWM_PERIOD   (PWM_PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (Enable),
    .period_tick (Period_Tick),
    .cnt         (cnt),
    .fwd         (FWD_B),
    .bwd         (BWD_B),
    .duty_sel    (Duty_SelB),
    .pwm         (PWM_B),
    .in1         (IN1_B),
    .in2         (IN2_B),
    .illegal     (illegal_b)
  );

endmodule

// File: tb/tb_dual_hbridge_pwm_driver.sv
// Directed self-checking bench for dual_hbridge_pwm_driver (default build,
// BRAKE_ON_STOP_EN undefined). A short PWM period keeps the run brief; the
// duty thresholds scale to 10/20/30/40 clocks.
module tb_dual_hbridge_pwm_driver;

  localparam int P = 40;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Enable;
  logic       FWD_A, BWD_A, FWD_B, BWD_B;
  logic [1:0] Duty_SelA, Duty_SelB;
  logic       PWM_A, PWM_B, IN1_A, IN2_A, IN1_B, IN2_B, Fault, Period_Tick;

  int checks = 0;
  int errors = 0;
  int both_high = 0;

  dual_hbridge_pwm_driver #(
    .PWM_PERIOD   (P),
    .DEAD_PERIODS (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Enable      (Enable),
    .FWD_A       (FWD_A),
    .BWD_A       (BWD_A),
    .FWD_B       (FWD_B),
    .BWD_B       (BWD_B),
    .Duty_SelA   (Duty_SelA),
    .Duty_SelB   (Duty_SelB),
    .PWM_A       (PWM_A),
    .PWM_B       (PWM_B),
    .IN1_A       (IN1_A),
    .IN2_A       (IN2_A),
    .IN1_B       (IN1_B),
    .IN2_B       (IN2_B),
    .Fault       (Fault),
    .Period_Tick (Period_Tick)
  );

  always #5 clk = ~clk;

  // Step ncyc clocks, sampling at each falling edge. Position within the
  // period starts at first_k; expected PWM is high while k < threshold.
  // Returns the number of mismatching cycles and the number of Fault cycles.
  task automatic run_cycles(input int first_k, input int ncyc,
                            input logic ea1, input logic ea2, input int eat,
                            input logic eb1, input logic eb2, input int ebt,
                            output int bad, output int faults);
    bad = 0;
    faults = 0;
    for (int i = 0; i < ncyc; i++) begin
      int   k;
      logic [6:0] exp_v;
      @(negedge clk);
      k = (first_k + i) % P;
      exp_v = {ea1, ea2, logic'(k < eat), eb1, eb2, logic'(k < ebt), logic'(k == P - 1)};
      if ({IN1_A, IN2_A, PWM_A, IN1_B, IN2_B, PWM_B, Period_Tick} !== exp_v) bad++;
      if ((IN1_A && IN2_A) || (IN1_B && IN2_B)) both_high++;
      if (Fault) faults++;
    end
  endtask

  // Count falling edges until Period_Tick, bounded at two periods
  task automatic count_to_tick(output int n);
    n = 0;
    while (n < 2 * P) begin
      @(negedge clk);
      n++;
      if (Period_Tick) break;
    end
  endtask

  task automatic test_reset;
    int n;
    checks++;
    if ({PWM_A, PWM_B, IN1_A, IN2_A, IN1_B, IN2_B, Fault, Period_Tick} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {PWM_A, PWM_B, IN1_A, IN2_A, IN1_B, IN2_B, Fault, Period_Tick});
    end
    rst = 1'b0;
    count_to_tick(n);
    checks++;
    if (n !== P - 1) begin
      errors++;
      $display("FAIL reset_first_tick: tick after %0d clocks expected %0d", n, P - 1);
    end
  endtask

  task automatic test_fwd_duty;
    int bad, f;
    Enable = 1'b1; FWD_A = 1'b1; Duty_SelA = 2'b10;
    #1;
    checks++;
    if ({IN1_A, IN2_A, PWM_A} !== 3'b000) begin
      errors++;
      $display("FAIL fwd_latency: IN1/IN2/PWM_A=%b before boundary expected 000", {IN1_A, IN2_A, PWM_A});
    end
    run_cycles(0, 2 * P, 1'b1, 1'b0, 30, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fwd_75pct: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (f !== 0) begin
      errors++;
      $display("FAIL fwd_no_fault: %0d fault cycles expected 0", f);
    end
  endtask

  task automatic test_reversal;
    int bad, b1, b2, f;
    FWD_A = 1'b0; BWD_A = 1'b1;
    run_cycles(0, D * P, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reversal_dead: %0d bad cycles expected 0", bad);
    end
    run_cycles(0, P, 1'b0, 1'b1, 30, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reversal_bwd: %0d bad cycles expected 0", bad);
    end
    // Request back to BWD after one dead period must not shorten the interval
    FWD_A = 1'b1; BWD_A = 1'b0;
    run_cycles(0, P, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, b1, f);
    FWD_A = 1'b0; BWD_A = 1'b1;
    run_cycles(0, (D - 1) * P, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, b2, f);
    checks++;
    if (b1 + b2 !== 0) begin
      errors++;
      $display("FAIL retract_dead_full: %0d bad cycles expected 0", b1 + b2);
    end
    run_cycles(0, P, 1'b0, 1'b1, 30, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL retract_bwd: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (both_high !== 0) begin
      errors++;
      $display("FAIL no_shoot_through: IN1=IN2=1 seen %0d cycles expected 0", both_high);
    end
  endtask

  task automatic test_duty_change;
    int bad, b1, b2, f;
    FWD_B = 1'b1; Duty_SelB = 2'b00;
    run_cycles(0, P, 1'b0, 1'b1, 30, 1'b1, 1'b0, 10, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b_25pct: %0d bad cycles expected 0", bad);
    end
    run_cycles(0, P / 2, 1'b0, 1'b1, 30, 1'b1, 1'b0, 10, b1, f);
    Duty_SelB = 2'b11;
    run_cycles(P / 2, P / 2, 1'b0, 1'b1, 30, 1'b1, 1'b0, 10, b2, f);
    checks++;
    if (b1 + b2 !== 0) begin
      errors++;
      $display("FAIL b_midperiod_change: %0d bad cycles expected 0", b1 + b2);
    end
    run_cycles(0, 2 * P, 1'b0, 1'b1, 30, 1'b1, 1'b0, 40, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b_100pct_wrap: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_illegal;
    int bad, f;
    FWD_A = 1'b1;  // BWD_A already 1
    #1;
    checks++;
    if (Fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_at_tick: Fault=%b expected 1", Fault);
    end
    run_cycles(0, P, 1'b0, 1'b0, 0, 1'b1, 1'b0, 40, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL illegal_a_stop: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (f !== 1) begin
      errors++;
      $display("FAIL fault_one_clock: Fault high %0d cycles in period expected 1", f);
    end
    BWD_B = 1'b1;  // both channels illegal
    #1;
    checks++;
    if (Fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_both: Fault=%b expected 1", Fault);
    end
    run_cycles(0, P, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0 || f !== 1) begin
      errors++;
      $display("FAIL illegal_both_stop: %0d bad cycles, %0d fault cycles expected 0 and 1", bad, f);
    end
  endtask

  task automatic test_enable;
    int bad, f;
    FWD_A = 1'b1; BWD_A = 1'b0; Duty_SelA = 2'b01;
    FWD_B = 1'b0; BWD_B = 1'b1; Duty_SelB = 2'b01;
    run_cycles(0, P, 1'b1, 1'b0, 20, 1'b0, 1'b1, 20, bad, f);
    checks++;
    if (bad !== 0 || f !== 0) begin
      errors++;
      $display("FAIL enable_run: %0d bad cycles, %0d fault cycles expected 0 and 0", bad, f);
    end
    Enable = 1'b0;
    run_cycles(0, 2 * P, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL enable_drop_stop: %0d bad cycles expected 0", bad);
    end
    Enable = 1'b1;
    run_cycles(0, P, 1'b1, 1'b0, 20, 1'b0, 1'b1, 20, bad, f);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL enable_resume: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int bad, f, n;
    Duty_SelA = 2'b11;
    run_cycles(0, P, 1'b1, 1'b0, 40, 1'b0, 1'b1, 20, bad, f);
    run_cycles(0, P / 4, 1'b1, 1'b0, 40, 1'b0, 1'b1, 20, n, f);
    checks++;
    if (bad + n !== 0 || PWM_A !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_run: %0d bad cycles PWM_A=%b expected 0 and 1", bad + n, PWM_A);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({PWM_A, PWM_B, IN1_A, IN2_A, IN1_B, IN2_B, Fault, Period_Tick} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 00000000",
               {PWM_A, PWM_B, IN1_A, IN2_A, IN1_B, IN2_B, Fault, Period_Tick});
    end
    FWD_A = 1'b0; BWD_B = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_to_tick(n);
    checks++;
    if (n !== P - 1) begin
      errors++;
      $display("FAIL reset_mid_restart: tick after %0d clocks expected %0d", n, P - 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    Enable = 1'b0;
    FWD_A = 1'b0; BWD_A = 1'b0; FWD_B = 1'b0; BWD_B = 1'b0;
    Duty_SelA = 2'b00; Duty_SelB = 2'b00;
    repeat (3) @(negedge clk);
    test_reset;
    test_fwd_duty;
    test_reversal;
    test_duty_change;
    test_illegal;
    test_enable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
